ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arb_pkg.sv | 20 ++
 rtl/ram_arbiter_if.sv | 55 +++++
 rtl/ram_arbiter_rr_pick.sv | 33 +++
 rtl/ram_arbiter.sv | 99 +++++++++
 tb/tb_ram_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types and defaults for the RAM arbiter.
// Imported by the interface, the picker and the top.
package ram_arb_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 32;
  localparam int IO_ADDR    = 0;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  typedef enum logic {
    PORT_A,
    PORT_B
  } owner_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: request ports A/B, RAM port and host IO tap.
// slave = arbiter side, master = requesters/RAM side.
interface ram_arbiter_if
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              a_req;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_gnt;
  logic              a_done;
  logic [DATA_W-1:0] a_rdata;

  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_gnt;
  logic              b_done;
  logic [DATA_W-1:0] b_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  logic [DATA_W-1:0] io_dout;
  logic              io_valid;
  logic              busy;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    output a_gnt, a_done, a_rdata,
    input  b_req, b_we, b_addr, b_wdata,
    output b_gnt, b_done, b_rdata,
    output mem_addr, mem_wdata, mem_we,
    input  mem_rdata,
    output io_dout, io_valid, busy
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    input  a_gnt, a_done, a_rdata,
    output b_req, b_we, b_addr, b_wdata,
    input  b_gnt, b_done, b_rdata,
    input  mem_addr, mem_wdata, mem_we,
    output mem_rdata,
    input  io_dout, io_valid, busy
  );

endinterface

// File: rtl/ram_arbiter_rr_pick.sv
// rr_pick: 2-way round-robin winner select with priority pointer.
// The pointer names the port that wins the next conflict.
module rr_pick
  import ram_arb_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   a_req,
  input  logic   b_req,
  input  logic   take,
  output owner_t win
);

  owner_t ptr;

  always_comb begin
    win = PORT_A;
    unique case (1'b1)
      a_req && b_req: win = ptr;
      b_req:          win = PORT_B;
      default:        win = PORT_A;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= PORT_A;
    end else if (take) begin
      ptr <= (win == PORT_A) ? PORT_B : PORT_A;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one RAM port between core (A) and host (B).
// Define ARB_ROUND_ROBIN_EN for round-robin; default is fixed A-first.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input logic          clk,
  input logic          reset,
  ram_arbiter_if.slave bus
);

  state_t            state;
  owner_t            owner;
  owner_t            win;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] a_rdata_q;
  logic [DATA_W-1:0] b_rdata_q;
  logic              can_acc;
  logic              any_req;
  logic              accept;

  // Grants are combinational, so gate them with reset explicitly.
  assign can_acc = reset && (state == IDLE || state == RESP);
  assign any_req = bus.a_req || bus.b_req;
  assign accept  = can_acc && any_req;

`ifdef ARB_ROUND_ROBIN_EN
  rr_pick u_pick (
    .clk   (clk),
    .reset (reset),
    .a_req (bus.a_req),
    .b_req (bus.b_req),
    .take  (accept),
    .win   (win)
  );
`else
  assign win = bus.a_req ? PORT_A : PORT_B;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      owner     <= PORT_A;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      unique case (state)
        IDLE, RESP: begin
          if (any_req) begin
            state <= ACCESS;
            owner <= win;
            if (win == PORT_A) begin
              we_q    <= bus.a_we;
              addr_q  <= bus.a_addr;
              wdata_q <= bus.a_wdata;
            end else begin
              we_q    <= bus.b_we;
              addr_q  <= bus.b_addr;
              wdata_q <= bus.b_wdata;
            end
          end else begin
            state <= IDLE;
          end
        end
        ACCESS: begin
          state <= RESP;
          if (!we_q && owner == PORT_A) a_rdata_q <= bus.mem_rdata;
          if (!we_q && owner == PORT_B) b_rdata_q <= bus.mem_rdata;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.a_gnt  = accept && (win == PORT_A);
  assign bus.b_gnt  = accept && (win == PORT_B);
  assign bus.a_done = (state == RESP) && (owner == PORT_A);
  assign bus.b_done = (state == RESP) && (owner == PORT_B);

  assign bus.a_rdata = a_rdata_q;
  assign bus.b_rdata = b_rdata_q;

  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_we    = (state == ACCESS) && we_q;

  assign bus.io_dout  = wdata_q;
  assign bus.io_valid = (state == ACCESS) && we_q &&
                        (addr_q == ADDR_W'(IO_ADDR));
  assign bus.busy     = (state != IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: vector table, directed corner sequences and a
// randomized run against a transaction-level arbiter model.
module tb_ram_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk;
  logic reset;
  int   n_chk;
  int   n_pass;

  logic [31:0] ram [256];
  logic [31:0] model_mem [256];

  ram_arbiter_if #(.ADDR_W(8), .DATA_W(32)) bus ();

  ram_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.mem_rdata = ram[bus.mem_addr];
  always @(posedge clk) if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;

  typedef struct {
    logic        a_req;
    logic        a_we;
    logic [7:0]  a_addr;
    logic [31:0] a_wdata;
    logic        b_req;
    logic        b_we;
    logic [7:0]  b_addr;
    logic [31:0] b_wdata;
    logic        ea_gnt;
    logic        eb_gnt;
    logic        e_mwe;
    logic        e_iov;
    logic        ea_done;
    logic        eb_done;
    logic        e_busy;
    logic [31:0] e_rdata;
  } vec_t;

  typedef struct {
    int          g;
    bit          port;
    bit          we;
    logic [7:0]  addr;
    logic [31:0] data;
  } rec_t;

  vec_t tv[17];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic drive(logic ar, logic aw, logic [7:0] aa, logic [31:0] ad,
                       logic br, logic bw, logic [7:0] ba, logic [31:0] bd);
    bus.a_req = ar; bus.a_we = aw; bus.a_addr = aa; bus.a_wdata = ad;
    bus.b_req = br; bus.b_we = bw; bus.b_addr = ba; bus.b_wdata = bd;
  endtask

  function automatic vec_t mk(logic ar, logic aw, logic [7:0] aa,
                              logic [31:0] ad, logic br, logic bw,
                              logic [7:0] ba, logic [31:0] bd,
                              logic ga, logic gb, logic mw, logic iv,
                              logic da, logic db, logic bz,
                              logic [31:0] rd);
    vec_t v;
    v.a_req = ar; v.a_we = aw; v.a_addr = aa; v.a_wdata = ad;
    v.b_req = br; v.b_we = bw; v.b_addr = ba; v.b_wdata = bd;
    v.ea_gnt = ga; v.eb_gnt = gb; v.e_mwe = mw; v.e_iov = iv;
    v.ea_done = da; v.eb_done = db; v.e_busy = bz; v.e_rdata = rd;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    logic [31:0] dbe;
    logic [31:0] w5;
    rec_t        q[$];
    rec_t        pend[2];
    bit          pv[2];
    logic [31:0] last_rd[2];
    int          next_free;
    int          last_g;
    bit          pref_b;
    logic [7:0]  cur_addr;

    n_chk = 0;
    n_pass = 0;
    dbe = 32'hDEADBEEF;
    for (int i = 0; i < 256; i++) ram[i] = $urandom;
    ram[8'h10] = dbe;
    ram[8'h20] = 32'h20202020;
    ram[8'h30] = 32'h30303030;
    for (int i = 0; i < 256; i++) model_mem[i] = ram[i];

    // Reset with a request pending: no grant may escape.
    reset = 1'b0;
    drive(1, 0, 8'h10, 32'h0, 1, 1, 8'h00, 32'hFFFF);
    #12;
    chk("rst_a_gnt", 32'(bus.a_gnt), 0);
    chk("rst_b_gnt", 32'(bus.b_gnt), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 0);
    chk("rst_a_rdata", bus.a_rdata, 0);
    chk("rst_io_dout", bus.io_dout, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;

    tv[0]  = mk(1,0,8'h10,0, 0,0,0,0, 1,0,0,0, 0,0,0, 0);
    tv[1]  = mk(0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,1, 0);
    tv[2]  = mk(0,0,0,0, 0,0,0,0, 0,0,0,0, 1,0,1, dbe);
    tv[3]  = mk(0,0,0,0, 1,1,8'h00,32'h12345678, 0,1,0,0, 0,0,0, 0);
    tv[4]  = mk(0,0,0,0, 0,0,0,0, 0,0,1,1, 0,0,1, 0);
    tv[5]  = mk(0,0,0,0, 0,0,0,0, 0,0,0,0, 0,1,1, 0);
    tv[6]  = mk(0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0, 0);
    tv[7]  = mk(1,0,8'h10,0, 1,0,8'h10,0, 1,0,0,0, 0,0,0, 0);
    tv[8]  = mk(1,0,8'h10,0, 1,0,8'h10,0, 0,0,0,0, 0,0,1, 0);
    tv[9]  = mk(1,0,8'h10,0, 1,0,8'h10,0, !RR,RR,0,0, 1,0,1, dbe);
    tv[10] = mk(1,0,8'h10,0, 1,0,8'h10,0, 0,0,0,0, 0,0,1, 0);
    tv[11] = mk(1,0,8'h10,0, 1,0,8'h10,0, 1,0,0,0, !RR,RR,1, dbe);
    tv[12] = mk(1,0,8'h10,0, 1,0,8'h10,0, 0,0,0,0, 0,0,1, 0);
    tv[13] = mk(1,0,8'h10,0, 1,0,8'h10,0, !RR,RR,0,0, 1,0,1, dbe);
    tv[14] = mk(1,0,8'h10,0, 1,0,8'h10,0, 0,0,0,0, 0,0,1, 0);
    tv[15] = mk(0,0,0,0, 0,0,0,0, 0,0,0,0, !RR,RR,1, dbe);
    tv[16] = mk(0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0, 0);

    for (int i = 0; i < 17; i++) begin
      string s;
      s = $sformatf("v%0d", i);
      step();
      drive(tv[i].a_req, tv[i].a_we, tv[i].a_addr, tv[i].a_wdata,
            tv[i].b_req, tv[i].b_we, tv[i].b_addr, tv[i].b_wdata);
      @(negedge clk);
      chk({s, "_a_gnt"}, 32'(bus.a_gnt), 32'(tv[i].ea_gnt));
      chk({s, "_b_gnt"}, 32'(bus.b_gnt), 32'(tv[i].eb_gnt));
      chk({s, "_mem_we"}, 32'(bus.mem_we), 32'(tv[i].e_mwe));
      chk({s, "_io_valid"}, 32'(bus.io_valid), 32'(tv[i].e_iov));
      chk({s, "_a_done"}, 32'(bus.a_done), 32'(tv[i].ea_done));
      chk({s, "_b_done"}, 32'(bus.b_done), 32'(tv[i].eb_done));
      chk({s, "_busy"}, 32'(bus.busy), 32'(tv[i].e_busy));
      if (tv[i].ea_done) chk({s, "_a_rdata"}, bus.a_rdata, tv[i].e_rdata);
      if (tv[i].eb_done) chk({s, "_b_rdata"}, bus.b_rdata, tv[i].e_rdata);
      if (tv[i].e_iov) chk({s, "_io_dout"}, bus.io_dout, 32'h12345678);
    end
    chk("io_ram0", ram[0], 32'h12345678);
    model_mem[0] = 32'h12345678;

    // Back-to-back A reads of addresses 1..3.
    for (int k = 1; k <= 3; k++) begin
      step();
      drive(1, 0, 8'(k), 0, 0, 0, 0, 0);
      @(negedge clk);
      chk($sformatf("b2b_gnt%0d", k), 32'(bus.a_gnt), 1);
      chk($sformatf("b2b_busy%0d", k), 32'(bus.busy), 32'(k > 1));
      if (k > 1) chk($sformatf("b2b_rd%0d", k - 1), bus.a_rdata,
                     model_mem[k - 1]);
      step();
      drive(k < 3, 0, 8'(k + 1), 0, 0, 0, 0, 0);
      @(negedge clk);
      chk($sformatf("b2b_nogt%0d", k), 32'(bus.a_gnt), 0);
      chk($sformatf("b2b_busyx%0d", k), 32'(bus.busy), 1);
    end
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("b2b_done3", 32'(bus.a_done), 1);
    chk("b2b_rd3", bus.a_rdata, model_mem[3]);
    chk("b2b_busy_end", 32'(bus.busy), 1);
    step();
    @(negedge clk);

    // Payload change after grant is ignored.
    step();
    drive(1, 0, 8'h20, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("pl_gnt", 32'(bus.a_gnt), 1);
    step();
    drive(0, 0, 8'h30, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("pl_mem_addr", 32'(bus.mem_addr), 32'h20);
    step();
    @(negedge clk);
    chk("pl_done", 32'(bus.a_done), 1);
    chk("pl_rdata", bus.a_rdata, 32'h20202020);
    step();
    @(negedge clk);

    // Reset in the middle of an ACCESS write to 0x05.
    w5 = ram[5];
    step();
    drive(1, 1, 8'h05, 32'hCAFEF00D, 0, 0, 0, 0);
    @(negedge clk);
    chk("mr_gnt", 32'(bus.a_gnt), 1);
    step();
    chk("mr_mem_we", 32'(bus.mem_we), 1);
    #2;
    reset = 1'b0;
    #1;
    chk("mr_mem_we0", 32'(bus.mem_we), 0);
    chk("mr_busy0", 32'(bus.busy), 0);
    chk("mr_gnt0", 32'(bus.a_gnt), 0);
    chk("mr_addr0", 32'(bus.mem_addr), 0);
    chk("mr_wdata0", bus.mem_wdata, 0);
    chk("mr_iod0", bus.io_dout, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    step();
    @(negedge clk);
    chk("mr_no_done", 32'(bus.a_done), 0);
    chk("mr_idle", 32'(bus.busy), 0);
    chk("mr_ram5", ram[5], w5);
    step();
    drive(1, 0, 8'h10, 0, 1, 0, 8'h10, 0);
    @(negedge clk);
    chk("mr_ptr_a", 32'(bus.a_gnt), 1);
    chk("mr_ptr_b", 32'(bus.b_gnt), 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);

    // Randomized run against a transaction-level model.
    do_reset();
    for (int i = 0; i < 256; i++) model_mem[i] = ram[i];
    pv[0] = 0; pv[1] = 0;
    last_rd[0] = 0; last_rd[1] = 0;
    next_free = 0; last_g = -100; pref_b = 0; cur_addr = 0;
    for (int n = 0; n < 600; n++) begin
      bit          ga, gb, emw, eiv, ebz;
      bit          dn[2];
      rec_t        dr;
      rec_t        r;
      logic [31:0] eiod;
      int          w;
      step();
      for (int p = 0; p < 2; p++) begin
        if (!pv[p] && $urandom_range(2) == 0) begin
          pv[p] = 1;
          pend[p].we = 1'($urandom_range(1));
          pend[p].addr = ($urandom_range(3) == 0) ? 8'h00
                                                  : 8'($urandom_range(15));
          pend[p].data = $urandom;
        end
      end
      drive(pv[0], pv[0] ? pend[0].we : 1'($urandom_range(1)),
            pv[0] ? pend[0].addr : 8'($urandom), pend[0].data,
            pv[1], pv[1] ? pend[1].we : 1'($urandom_range(1)),
            pv[1] ? pend[1].addr : 8'($urandom), pend[1].data);
      ebz = (n - last_g == 1) || (n - last_g == 2);
      emw = 0; eiv = 0; eiod = 0; dn[0] = 0; dn[1] = 0; dr = pend[0];
      foreach (q[i]) begin
        if (q[i].g == n - 1) begin
          emw = q[i].we;
          eiv = q[i].we && q[i].addr == 8'h00;
          eiod = q[i].data;
          cur_addr = q[i].addr;
        end
        if (q[i].g == n - 2) begin
          dn[q[i].port] = 1;
          dr = q[i];
        end
      end
      ga = 0; gb = 0; w = 0;
      if (n >= next_free && (pv[0] || pv[1])) begin
        w = (pv[1] && (!pv[0] || (RR && pref_b))) ? 1 : 0;
        r = pend[w];
        r.g = n;
        r.port = w[0];
        if (r.we) model_mem[r.addr] = r.data;
        else r.data = model_mem[r.addr];
        q.push_back(r);
        next_free = n + 2;
        last_g = n;
        pref_b = (w == 0);
        ga = (w == 0);
        gb = (w == 1);
      end
      @(negedge clk);
      chk("rnd_a_gnt", 32'(bus.a_gnt), 32'(ga));
      chk("rnd_b_gnt", 32'(bus.b_gnt), 32'(gb));
      chk("rnd_busy", 32'(bus.busy), 32'(ebz));
      chk("rnd_mem_we", 32'(bus.mem_we), 32'(emw));
      chk("rnd_io_valid", 32'(bus.io_valid), 32'(eiv));
      chk("rnd_mem_addr", 32'(bus.mem_addr), 32'(cur_addr));
      chk("rnd_a_done", 32'(bus.a_done), 32'(dn[0]));
      chk("rnd_b_done", 32'(bus.b_done), 32'(dn[1]));
      if (eiv) chk("rnd_io_dout", bus.io_dout, eiod);
      if (dn[0] || dn[1]) begin
        if (!dr.we) last_rd[dr.port] = dr.data;
        if (dr.port == 0) chk("rnd_a_rdata", bus.a_rdata, last_rd[0]);
        else chk("rnd_b_rdata", bus.b_rdata, last_rd[1]);
      end
      if (ga || gb) pv[w] = 0;
      while (q.size() > 0 && q[0].g < n - 2) void'(q.pop_front());
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
